// File: rtl/eth_rx_filter.sv
// Ethernet RX destination/EtherType filter on a 512-bit Avalon-ST stream.
// Packets whose DA and EtherType match are forwarded through a one-deep
// output register. All other packets are discarded. Framing errors are
// counted: a non-SOP beat outside a packet, or an SOP beat inside a packet.
module eth_rx_filter #(
  parameter logic [47:0] MAC_ADDR     = 48'h02_00_00_00_00_01,
  parameter bit          ACCEPT_BCAST = 1'b1,
  parameter logic [15:0] ETYPE        = 16'h0800,
  parameter bit          ETYPE_CHECK  = 1'b1
) (
  input  logic         fifo_clk,
  input  logic         fifo_rst,
  // sink from the MAC RX FIFO
  input  logic [511:0] in_data,
  input  logic         in_valid,
  input  logic         in_sop,
  input  logic         in_eop,
  input  logic [5:0]   in_empty,
  output logic         in_ready,
  // source to the packet processor
  output logic [511:0] out_data,
  output logic         out_valid,
  output logic         out_sop,
  output logic         out_eop,
  output logic [5:0]   out_empty,
  input  logic         out_ready,
  // statistics
  output logic [31:0]  fwd_cnt,
  output logic [31:0]  drop_cnt,
  output logic [31:0]  err_cnt
);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_FWD  = 2'd1,
    ST_DROP = 2'd2
  } state_t;

  state_t       state_q;
  logic [511:0] out_data_q;
  logic         out_valid_q;
  logic         out_sop_q;
  logic         out_eop_q;
  logic [5:0]   out_empty_q;
  logic [31:0]  fwd_cnt_q;
  logic [31:0]  drop_cnt_q;
  logic [31:0]  err_cnt_q;

  logic [47:0]  dst_mac;
  logic [15:0]  eth_type;
  logic         sop_match;
  logic         xfer;
  logic         fwd_beat;
  logic         drop_pkt;
  logic         err_beat;

  // The output register can take a new beat when empty or being drained.
  assign in_ready = ~out_valid_q | out_ready;
  assign xfer     = in_valid & in_ready;

  // Header fields: byte 0 sits in the top byte lane.
  assign dst_mac  = in_data[511:464];
  assign eth_type = in_data[415:400];

  // Per-beat classification; the match only matters on SOP beats.
  always_comb begin
    sop_match = ((dst_mac == MAC_ADDR) || (ACCEPT_BCAST && (dst_mac == '1)))
                && (!ETYPE_CHECK || (eth_type == ETYPE));
    // An SOP always restarts classification, even inside a packet.
    fwd_beat  = xfer && (in_sop ? sop_match : (state_q == ST_FWD));
    drop_pkt  = xfer && in_sop && !sop_match;
    err_beat  = xfer && (in_sop ? (state_q != ST_IDLE) : (state_q == ST_IDLE));
  end

  // Packet FSM, output register and statistics counters.
  always_ff @(posedge fifo_clk) begin
    if (fifo_rst) begin
      state_q     <= ST_IDLE;
      out_data_q  <= '0;
      out_valid_q <= 1'b0;
      out_sop_q   <= 1'b0;
      out_eop_q   <= 1'b0;
      out_empty_q <= '0;
      fwd_cnt_q   <= '0;
      drop_cnt_q  <= '0;
      err_cnt_q   <= '0;
    end else begin
      // Output register: load a forwarded beat, or empty once drained.
      if (fwd_beat) begin
        out_data_q  <= in_data;
        out_valid_q <= 1'b1;
        out_sop_q   <= in_sop;
        out_eop_q   <= in_eop;
        out_empty_q <= in_empty;
      end else if (out_ready) begin
        out_valid_q <= 1'b0;
      end

      if (fwd_beat && in_eop) fwd_cnt_q  <= fwd_cnt_q + 32'd1;
      if (drop_pkt)           drop_cnt_q <= drop_cnt_q + 32'd1;
      if (err_beat)           err_cnt_q  <= err_cnt_q + 32'd1;

      if (xfer) begin
        if (in_sop) begin
          if (in_eop)         state_q <= ST_IDLE;
          else if (sop_match) state_q <= ST_FWD;
          else                state_q <= ST_DROP;
        end else begin
          case (state_q)
            ST_FWD:  if (in_eop) state_q <= ST_IDLE;
            ST_DROP: if (in_eop) state_q <= ST_IDLE;
            default: state_q <= ST_IDLE;
          endcase
        end
      end
    end
  end

  assign out_data  = out_data_q;
  assign out_valid = out_valid_q;
  assign out_sop   = out_sop_q;
  assign out_eop   = out_eop_q;
  assign out_empty = out_empty_q;
  assign fwd_cnt   = fwd_cnt_q;
  assign drop_cnt  = drop_cnt_q;
  assign err_cnt   = err_cnt_q;

endmodule

// File: tb/tb_eth_rx_filter.sv
// Testbench for eth_rx_filter: directed scenarios plus randomized traffic,
// checked against a packet-level reference model of the filter rules.
module tb_eth_rx_filter;

  localparam logic [47:0] MAC = 48'h02_00_00_00_00_01;
  localparam logic [47:0] BC  = 48'hFF_FF_FF_FF_FF_FF;

  typedef struct {
    logic [511:0] d;
    logic         sop;
    logic         eop;
    logic [5:0]   emp;
    int           stamp;
  } beat_t;

  logic         fifo_clk = 1'b0;
  logic         fifo_rst = 1'b1;
  logic [511:0] in_data  = '0;
  logic         in_valid = 1'b0;
  logic         in_sop   = 1'b0;
  logic         in_eop   = 1'b0;
  logic [5:0]   in_empty = '0;
  logic         in_ready;
  logic [511:0] out_data;
  logic         out_valid;
  logic         out_sop;
  logic         out_eop;
  logic [5:0]   out_empty;
  logic         out_ready = 1'b1;
  logic [31:0]  fwd_cnt, drop_cnt, err_cnt;

  int checks   = 0;
  int failures = 0;

  beat_t got_q[$];
  beat_t exp_q[$];
  int    cyc       = 0;
  int    ov_cnt    = 0;
  int    stall_cnt = 0;

  // reference model state: 0 = between packets, 1 = keeping, 2 = discarding
  int          m_mode = 0;
  logic [31:0] m_fwd  = '0;
  logic [31:0] m_drop = '0;
  logic [31:0] m_err  = '0;

  eth_rx_filter dut (
    .fifo_clk (fifo_clk),
    .fifo_rst (fifo_rst),
    .in_data  (in_data),
    .in_valid (in_valid),
    .in_sop   (in_sop),
    .in_eop   (in_eop),
    .in_empty (in_empty),
    .in_ready (in_ready),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_sop  (out_sop),
    .out_eop  (out_eop),
    .out_empty(out_empty),
    .out_ready(out_ready),
    .fwd_cnt  (fwd_cnt),
    .drop_cnt (drop_cnt),
    .err_cnt  (err_cnt)
  );

  always #5 fifo_clk = ~fifo_clk;

  initial begin
    #500000;
    $display("FAIL watchdog simulation did not finish, required finish before 500us");
    $fatal(1, "watchdog");
  end

  function automatic beat_t mk_beat(input logic [511:0] d, input logic s, input logic e,
                                    input logic [5:0] m, input int st);
    beat_t b;
    b.d = d; b.sop = s; b.eop = e; b.emp = m; b.stamp = st;
    return b;
  endfunction

  function automatic logic [511:0] mk_data(input logic [47:0] da, input logic [15:0] et);
    logic [511:0] d;
    for (int i = 0; i < 16; i++) d[i*32 +: 32] = $urandom();
    d[511:464] = da;
    d[415:400] = et;
    return d;
  endfunction

  function automatic bit ref_match(input logic [511:0] d);
    logic [47:0] da;
    logic [15:0] et;
    da = d[511:464];
    et = d[415:400];
    return ((da == MAC) || (da == BC)) && (et == 16'h0800);
  endfunction

  // Monitor and reference model, sampled on the falling edge (inputs and
  // outputs are stable here and describe the transfer at the next rising edge).
  always @(negedge fifo_clk) begin
    cyc <= cyc + 1;
    if (out_valid === 1'b1 && out_ready === 1'b1)
      got_q.push_back(mk_beat(out_data, out_sop, out_eop, out_empty, cyc));
    if (out_valid === 1'b1) ov_cnt <= ov_cnt + 1;
    if (in_valid && in_ready !== 1'b1) stall_cnt <= stall_cnt + 1;
    if (fifo_rst) begin
      m_mode <= 0; m_fwd <= '0; m_drop <= '0; m_err <= '0;
    end else if (in_valid && in_ready === 1'b1) begin
      if (in_sop) begin
        if (m_mode != 0) m_err <= m_err + 1;
        if (ref_match(in_data)) begin
          exp_q.push_back(mk_beat(in_data, in_sop, in_eop, in_empty, cyc));
          if (in_eop) begin m_fwd <= m_fwd + 1; m_mode <= 0; end
          else m_mode <= 1;
        end else begin
          m_drop <= m_drop + 1;
          m_mode <= in_eop ? 0 : 2;
        end
      end else if (m_mode == 0) begin
        m_err <= m_err + 1;
      end else if (m_mode == 1) begin
        exp_q.push_back(mk_beat(in_data, in_sop, in_eop, in_empty, cyc));
        if (in_eop) begin m_fwd <= m_fwd + 1; m_mode <= 0; end
      end else if (in_eop) begin
        m_mode <= 0;
      end
    end
  end

  task automatic send_beat(input logic [511:0] d, input logic s, input logic e,
                           input logic [5:0] m);
    int n;
    in_data = d; in_sop = s; in_eop = e; in_empty = m; in_valid = 1'b1;
    n = 0;
    forever begin
      @(negedge fifo_clk);
      if (in_ready === 1'b1) break;
      n++;
      if (n > 200) begin
        checks++; failures++;
        $display("FAIL send_timeout in_ready=%b required 1 within 200 cycles", in_ready);
        break;
      end
    end
    @(posedge fifo_clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic do_reset();
    fifo_rst = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
    repeat (2) @(posedge fifo_clk);
    #1 fifo_rst = 1'b0;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic drain();
    out_ready = 1'b1; in_valid = 1'b0;
    repeat (4) @(posedge fifo_clk);
    #1;
  endtask

  task automatic test_reset();
    fifo_rst = 1'b1; out_ready = 1'b0;
    in_data = mk_data(MAC, 16'h0800); in_sop = 1'b1; in_eop = 1'b1; in_valid = 1'b1;
    repeat (2) @(posedge fifo_clk);
    @(negedge fifo_clk);
    checks++;
    if (out_valid !== 1'b0 || out_sop !== 1'b0 || out_eop !== 1'b0 || out_data !== '0 || out_empty !== '0) begin
      failures++;
      $display("FAIL reset_outputs got v=%b s=%b e=%b emp=%0d data_nonzero=%b required all 0",
               out_valid, out_sop, out_eop, out_empty, |out_data);
    end
    checks++;
    if (fwd_cnt !== 0 || drop_cnt !== 0 || err_cnt !== 0) begin
      failures++;
      $display("FAIL reset_counters got fwd=%0d drop=%0d err=%0d required 0/0/0", fwd_cnt, drop_cnt, err_cnt);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_in_ready got %b required 1", in_ready);
    end
    @(posedge fifo_clk); #1;
    in_valid = 1'b0; out_ready = 1'b1; fifo_rst = 1'b0;
    got_q.delete(); exp_q.delete();
  endtask

  task automatic test_single_fwd();
    logic [511:0] d;
    do_reset();
    d = mk_data(MAC, 16'h0800);
    send_beat(d, 1'b1, 1'b1, 6'd5);
    drain();
    checks++;
    if (got_q.size() != 1) begin
      failures++;
      $display("FAIL single_count got %0d beats required 1", got_q.size());
    end else begin
      checks++;
      if (got_q[0].d !== d || got_q[0].sop !== 1'b1 || got_q[0].eop !== 1'b1 || got_q[0].emp !== 6'd5) begin
        failures++;
        $display("FAIL single_beat got s=%b e=%b emp=%0d d=%h required s=1 e=1 emp=5 d=%h",
                 got_q[0].sop, got_q[0].eop, got_q[0].emp, got_q[0].d, d);
      end
      checks++;
      if (exp_q.size() != 1 || got_q[0].stamp != exp_q[0].stamp + 1) begin
        failures++;
        $display("FAIL single_latency got out cycle %0d required accept cycle + 1", got_q[0].stamp);
      end
    end
    checks++;
    if (fwd_cnt !== 32'd1 || drop_cnt !== 32'd0) begin
      failures++;
      $display("FAIL single_counters got fwd=%0d drop=%0d required fwd=1 drop=0", fwd_cnt, drop_cnt);
    end
  endtask

  task automatic test_drop();
    int ov0, st0;
    do_reset();
    ov0 = ov_cnt; st0 = stall_cnt;
    for (int k = 0; k < 3; k++)
      send_beat(mk_data(BC, 16'h86DD), k == 0, k == 2, 6'd0);
    drain();
    checks++;
    if (ov_cnt != ov0 || got_q.size() != 0) begin
      failures++;
      $display("FAIL drop_outvalid got %0d valid cycles required 0", ov_cnt - ov0);
    end
    checks++;
    if (stall_cnt != st0) begin
      failures++;
      $display("FAIL drop_in_ready got %0d stalled cycles required 0", stall_cnt - st0);
    end
    checks++;
    if (drop_cnt !== 32'd1 || fwd_cnt !== 32'd0 || err_cnt !== 32'd0) begin
      failures++;
      $display("FAIL drop_counters got drop=%0d fwd=%0d err=%0d required 1/0/0", drop_cnt, fwd_cnt, err_cnt);
    end
  endtask

  task automatic test_backpressure();
    logic [511:0] d [4];
    do_reset();
    for (int k = 0; k < 4; k++) d[k] = mk_data(MAC, 16'h0800);
    fork
      begin
        for (int k = 0; k < 4; k++) send_beat(d[k], k == 0, k == 3, 6'(k));
      end
      begin
        out_ready = 1'b1;
        @(posedge fifo_clk); #1;
        out_ready = 1'b0;
        repeat (3) begin
          @(negedge fifo_clk);
          checks++;
          if (out_valid !== 1'b1 || in_ready !== 1'b0 || out_data !== d[0] || out_sop !== 1'b1) begin
            failures++;
            $display("FAIL bp_hold got v=%b in_ready=%b sop=%b data_ok=%b required v=1 in_ready=0 sop=1 data_ok=1",
                     out_valid, in_ready, out_sop, out_data === d[0]);
          end
          @(posedge fifo_clk); #1;
        end
        out_ready = 1'b1;
      end
    join
    drain();
    checks++;
    if (got_q.size() != 4) begin
      failures++;
      $display("FAIL bp_count got %0d beats required 4", got_q.size());
    end
    for (int k = 0; k < 4; k++) begin
      if (k < got_q.size()) begin
        checks++;
        if (got_q[k].d !== d[k] || got_q[k].sop !== (k == 0) || got_q[k].eop !== (k == 3) || got_q[k].emp !== 6'(k)) begin
          failures++;
          $display("FAIL bp_beat%0d got s=%b e=%b emp=%0d data_ok=%b required s=%0d e=%0d emp=%0d data_ok=1",
                   k, got_q[k].sop, got_q[k].eop, got_q[k].emp, got_q[k].d === d[k], k == 0, k == 3, k);
        end
      end
    end
    checks++;
    if (fwd_cnt !== 32'd1) begin
      failures++;
      $display("FAIL bp_fwd_cnt got %0d required 1", fwd_cnt);
    end
  endtask

  task automatic test_framing_err();
    logic [511:0] d [4];
    do_reset();
    for (int k = 0; k < 4; k++) d[k] = mk_data(MAC, 16'h0800);
    send_beat(mk_data(MAC, 16'h0800), 1'b0, 1'b0, 6'd0);
    send_beat(d[0], 1'b1, 1'b0, 6'd0);
    send_beat(d[1], 1'b0, 1'b0, 6'd0);
    send_beat(d[2], 1'b1, 1'b0, 6'd0);
    send_beat(d[3], 1'b0, 1'b1, 6'd9);
    drain();
    checks++;
    if (err_cnt !== 32'd2 || fwd_cnt !== 32'd1 || drop_cnt !== 32'd0) begin
      failures++;
      $display("FAIL ferr_counters got err=%0d fwd=%0d drop=%0d required 2/1/0", err_cnt, fwd_cnt, drop_cnt);
    end
    checks++;
    if (got_q.size() != 4) begin
      failures++;
      $display("FAIL ferr_count got %0d beats required 4", got_q.size());
    end
    for (int k = 0; k < 4; k++) begin
      if (k < got_q.size()) begin
        checks++;
        if (got_q[k].d !== d[k] || got_q[k].sop !== (k == 0 || k == 2)) begin
          failures++;
          $display("FAIL ferr_beat%0d got sop=%b data_ok=%b required sop=%0d data_ok=1",
                   k, got_q[k].sop, got_q[k].d === d[k], k == 0 || k == 2);
        end
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [511:0] d [5];
    logic [511:0] n;
    do_reset();
    for (int k = 0; k < 5; k++) d[k] = mk_data(MAC, 16'h0800);
    n = mk_data(MAC, 16'h0800);
    send_beat(d[0], 1'b1, 1'b0, 6'd0);
    fifo_rst = 1'b1;
    send_beat(d[1], 1'b0, 1'b0, 6'd0);
    fifo_rst = 1'b0;
    checks++;
    if (out_valid !== 1'b0 || fwd_cnt !== 0 || drop_cnt !== 0 || err_cnt !== 0) begin
      failures++;
      $display("FAIL rstmid_state got v=%b fwd=%0d drop=%0d err=%0d required 0/0/0/0",
               out_valid, fwd_cnt, drop_cnt, err_cnt);
    end
    for (int k = 2; k < 5; k++) send_beat(d[k], 1'b0, k == 4, 6'd0);
    send_beat(n, 1'b1, 1'b1, 6'd3);
    drain();
    checks++;
    if (err_cnt !== 32'd3 || fwd_cnt !== 32'd1) begin
      failures++;
      $display("FAIL rstmid_counters got err=%0d fwd=%0d required err=3 fwd=1", err_cnt, fwd_cnt);
    end
    checks++;
    if (got_q.size() != 2) begin
      failures++;
      $display("FAIL rstmid_count got %0d beats required 2", got_q.size());
    end else begin
      checks++;
      if (got_q[0].d !== d[0] || got_q[1].d !== n || got_q[1].eop !== 1'b1 || got_q[0].eop !== 1'b0) begin
        failures++;
        $display("FAIL rstmid_beats got b0_ok=%b b1_ok=%b eop0=%b eop1=%b required 1 1 0 1",
                 got_q[0].d === d[0], got_q[1].d === n, got_q[0].eop, got_q[1].eop);
      end
    end
  endtask

  task automatic test_back_to_back();
    int st0;
    logic [511:0] d;
    do_reset();
    st0 = stall_cnt;
    for (int i = 0; i < 100; i++) begin
      if (i % 2 == 0) d = mk_data(MAC, 16'h0800);
      else            d = mk_data({16'h0A00, 32'($urandom())}, 16'h0800);
      send_beat(d, 1'b1, 1'b1, 6'($urandom_range(0, 63)));
    end
    drain();
    checks++;
    if (got_q.size() != 50 || exp_q.size() != 50) begin
      failures++;
      $display("FAIL b2b_count got %0d beats (model %0d) required 50", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        checks++;
        if (got_q[i].d !== exp_q[i].d || got_q[i].emp !== exp_q[i].emp || got_q[i].sop !== 1'b1 || got_q[i].eop !== 1'b1) begin
          failures++;
          $display("FAIL b2b_beat%0d got emp=%0d s=%b e=%b data_ok=%b required emp=%0d s=1 e=1 data_ok=1",
                   i, got_q[i].emp, got_q[i].sop, got_q[i].eop, got_q[i].d === exp_q[i].d, exp_q[i].emp);
        end
      end
    end
    checks++;
    if (fwd_cnt !== 32'd50 || drop_cnt !== 32'd50 || err_cnt !== 32'd0) begin
      failures++;
      $display("FAIL b2b_counters got fwd=%0d drop=%0d err=%0d required 50/50/0", fwd_cnt, drop_cnt, err_cnt);
    end
    checks++;
    if (stall_cnt != st0 || (got_q.size() == 50 && got_q[49].stamp - got_q[0].stamp != 98)) begin
      failures++;
      $display("FAIL b2b_bubbles got stalls=%0d span=%0d required stalls=0 span=98",
               stall_cnt - st0, got_q.size() == 50 ? got_q[49].stamp - got_q[0].stamp : -1);
    end
    got_q.delete(); exp_q.delete();
    for (int i = 0; i < 8; i++) send_beat(mk_data(BC, 16'h0800), 1'b1, 1'b1, 6'd0);
    drain();
    checks++;
    if (got_q.size() != 8 || got_q[7].stamp - got_q[0].stamp != 7) begin
      failures++;
      $display("FAIL b2b_stream got %0d beats span=%0d required 8 beats span=7",
               got_q.size(), got_q.size() == 8 ? got_q[7].stamp - got_q[0].stamp : -1);
    end
  endtask

  task automatic test_random();
    bit done;
    int r, len;
    logic [47:0] da;
    logic [15:0] et;
    do_reset();
    done = 1'b0;
    fork
      begin
        for (int p = 0; p < 40; p++) begin
          r = $urandom_range(0, 9);
          if (r == 0) begin
            send_beat(mk_data(MAC, 16'h0800), 1'b0, $urandom_range(0, 1) == 1, 6'd0);
          end else begin
            len = $urandom_range(1, 4);
            case ($urandom_range(0, 2))
              0:       da = MAC;
              1:       da = BC;
              default: da = {16'h0C00, 32'($urandom())};
            endcase
            et = ($urandom_range(0, 3) != 0) ? 16'h0800 : 16'h86DD;
            for (int k = 0; k < len; k++)
              send_beat(mk_data(da, et), k == 0, (k == len - 1) && (r != 1),
                        6'($urandom_range(0, 63)));
          end
          repeat ($urandom_range(0, 2)) @(posedge fifo_clk);
          #1;
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(posedge fifo_clk); #1;
          out_ready = ($urandom_range(0, 3) != 0);
        end
        out_ready = 1'b1;
      end
    join
    drain();
    checks++;
    if (got_q.size() != exp_q.size()) begin
      failures++;
      $display("FAIL rand_count got %0d beats required %0d", got_q.size(), exp_q.size());
    end
    for (int i = 0; i < exp_q.size(); i++) begin
      if (i < got_q.size()) begin
        checks++;
        if (got_q[i].d !== exp_q[i].d || got_q[i].sop !== exp_q[i].sop ||
            got_q[i].eop !== exp_q[i].eop || got_q[i].emp !== exp_q[i].emp) begin
          failures++;
          $display("FAIL rand_beat%0d got s=%b e=%b emp=%0d data_ok=%b required s=%b e=%b emp=%0d data_ok=1",
                   i, got_q[i].sop, got_q[i].eop, got_q[i].emp, got_q[i].d === exp_q[i].d,
                   exp_q[i].sop, exp_q[i].eop, exp_q[i].emp);
        end
      end
    end
    checks++;
    if (fwd_cnt !== m_fwd || drop_cnt !== m_drop || err_cnt !== m_err) begin
      failures++;
      $display("FAIL rand_counters got fwd=%0d drop=%0d err=%0d required %0d/%0d/%0d",
               fwd_cnt, drop_cnt, err_cnt, m_fwd, m_drop, m_err);
    end
  endtask

  initial begin
    test_reset();
    test_single_fwd();
    test_drop();
    test_backpressure();
    test_framing_err();
    test_reset_mid();
    test_back_to_back();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/eth_rx_filter.md
ETH_RX_FILTER -- requirements
Module: eth_rx_filter

Interface
REQ-001 SHALL have parameter MAC_ADDR, default 48'h02_00_00_00_00_01, the local unicast destination MAC accepted.
REQ-002 SHALL have parameter ACCEPT_BCAST, default 1, to also accept DA 48'hFF_FF_FF_FF_FF_FF.
REQ-003 SHALL have parameter ETYPE, default 16'h0800, the required EtherType.
REQ-004 SHALL have parameter ETYPE_CHECK, default 1; when 0, EtherType is ignored.
REQ-005 SHALL have port fifo_clk, input, 1, the single clock; all logic on its rising edge.
REQ-006 SHALL have port fifo_rst, input, 1, reset; synchronous, active-high.
REQ-007 SHALL have ports in_data/in_valid/in_sop/in_eop/in_empty/in_ready: input 512/1/1/1/6, output 1; Avalon-ST sink fed by the MAC RX FIFO output.
REQ-008 SHALL have ports out_data/out_valid/out_sop/out_eop/out_empty/out_ready: output 512/1/1/1/6, input 1; Avalon-ST source to the packet processor.
REQ-009 SHALL have outputs fwd_cnt, drop_cnt, err_cnt, each 32 bits: forwarded packets, filtered packets, framing errors.

Function
REQ-010 SHALL treat a beat as transferred when in_valid and in_ready are both 1 on a clock edge.
REQ-011 SHALL drive in_ready = ~out_valid | out_ready combinationally, in every state.
REQ-012 SHALL take byte 0 of a beat from in_data[511:504]; DA = in_data[511:464]; EtherType = in_data[415:400].
REQ-013 SHALL decide, on each transferred SOP beat, match = (DA==MAC_ADDR or (ACCEPT_BCAST and DA==all-ones)) and (ETYPE_CHECK==0 or EtherType==ETYPE).
REQ-014 SHALL implement states IDLE, FWD, DROP.
REQ-015 IDLE: SOP beat with match -> forward beat; go FWD unless in_eop set.
REQ-016 IDLE: SOP beat without match -> discard beat; go DROP unless in_eop set.
REQ-017 IDLE: transferred beat without SOP -> discard; err_cnt increments; stay IDLE.
REQ-018 FWD: non-SOP beats forwarded; a beat with in_eop returns to IDLE.
REQ-019 DROP: non-SOP beats discarded; a beat with in_eop returns to IDLE.
REQ-020 FWD or DROP: SOP beat arriving -> err_cnt increments; beat reclassified per REQ-015/016 as if in IDLE; the previous packet is not closed on the output.
REQ-021 SHALL register forwarded beats: out_* equal the forwarded in_* one cycle after transfer (latency 1).
REQ-022 SHALL hold out_* stable while out_valid=1 and out_ready=0.
REQ-023 SHALL clear out_valid on a cycle where out_ready=1 and no beat is forwarded.
REQ-024 SHALL sustain one beat per cycle when out_ready stays 1 (no bubbles).
REQ-025 SHALL increment fwd_cnt once per forwarded EOP beat, drop_cnt once per discarded packet on its SOP beat; counters wrap modulo 2^32.
REQ-026 SHALL allow one SOP+EOP beat to complete a whole packet, counted once.
REQ-027 SHALL pass in_empty through unchanged on forwarded beats; it is ignored on discarded beats.

Reset
REQ-028 While fifo_rst=1: state IDLE, out_valid=0, out_sop=0, out_eop=0, out_data=0, out_empty=0, all counters 0; in_ready=1.
REQ-029 Reset asserted mid-packet SHALL abandon it with no EOP emitted; the first beat after release is classified per IDLE rules.

Verification
REQ-030 Single beat, SOP+EOP, DA=02:00:00:00:00:01, EtherType 0x0800, out_ready=1 -> identical beat on out_* next cycle; fwd_cnt=1.
REQ-031 3-beat packet, DA=FF:FF:FF:FF:FF:FF, EtherType 0x86DD, ETYPE_CHECK=1 -> no out_valid; in_ready stays 1; drop_cnt=1, fwd_cnt=0.
REQ-032 4-beat matching packet, out_ready low on cycles 2-4 -> in_ready low while out_valid held; all 4 beats delivered in order; data unchanged.
REQ-033 Non-SOP beat in IDLE, then SOP during FWD of a 3-beat matching packet -> err_cnt=2; new packet forwarded from its SOP.
REQ-034 fifo_rst pulsed 1 cycle in beat 2 of a 5-beat matching packet -> out_valid=0 and counters 0 next cycle; remaining beats discarded (err_cnt=3); next matching packet forwards normally.
REQ-035 100 back-to-back single-beat packets alternating match/no-match, out_ready=1 -> 50 out beats, no bubbles, fwd_cnt=50, drop_cnt=50.
